i4002_master: RTL

Bus initiator for the 4004-style multiplexed 4-bit bus, driving one or more `i4002` RAM/output chips from a host request port. It generates the cp1/cp2/sync bus timing. Each host request becomes an SRC instruction cycle followed by an I/O (IOR) instruction cycle, and read data comes back as a response. It sits between a test harness or CPU-side controller and the shared `data`/`cm` lines of the RAM bank.

---
 rtl/i4002_master.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/i4002_master.sv
// Bus initiator for the 4004-style multiplexed bus: turns each host request into
// an SRC cycle followed by an I/O cycle and returns read data as a response.
module i4002_master (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_op,
   input  logic [1:0] req_chip,
   input  logic [7:0] req_addr,
   input  logic [3:0] req_wdata,
   output logic       rsp_valid,
   output logic [3:0] rsp_rdata,
   output logic       cp1,
   output logic       cp2,
   output logic       sync,
   output logic       cm,
   output logic       bus_reset_n,
   inout  wire  [3:0] data
);
   // state    | meaning
   // CYC_NOP  | idle instruction cycle, all-zero opcode, cm low
   // CYC_SRC  | send register control: chip in A3, address in E2/E3
   // CYC_IO   | I/O function in M2; write data or read capture in E2
   typedef enum logic [1:0] {CYC_NOP, CYC_SRC, CYC_IO} cyc_t;

   localparam logic [3:0] SRC_OPA = 4'b0001;
   localparam logic [3:0] OP_SRC  = 4'b0010;
   localparam logic [3:0] OP_IOR  = 4'b1110;
   localparam logic [3:0] OP_RDR  = 4'b1010;

   localparam logic [2:0] S_A1 = 3'd0;
   localparam logic [2:0] S_A2 = 3'd1;
   localparam logic [2:0] S_A3 = 3'd2;
   localparam logic [2:0] S_M1 = 3'd3;
   localparam logic [2:0] S_M2 = 3'd4;
   localparam logic [2:0] S_E1 = 3'd5;
   localparam logic [2:0] S_E2 = 3'd6;
   localparam logic [2:0] S_E3 = 3'd7;

   logic [1:0] r_tick;
   logic [2:0] r_slot;
   cyc_t       r_cyc;
   logic       r_pending;
   logic       r_req_ready;
   logic [3:0] r_op;
   logic [1:0] r_chip;
   logic [7:0] r_addr;
   logic [3:0] r_wdata;
   logic [3:0] r_capt;
   logic       r_rsp_valid;
   logic [3:0] r_rsp_rdata;
   logic       r_cp1;
   logic       r_cp2;
   logic       r_sync;
   logic       r_cm;
   logic       r_oe;
   logic [3:0] r_dout;
   logic       r_rst_d;
   logic       r_bus_reset_n;

   logic [1:0] w_tick_nxt;
   logic [2:0] w_slot_nxt;
   cyc_t       w_cyc_nxt;
   logic       w_oe_nxt;
   logic [3:0] w_dout_nxt;
   logic       w_accept;
   logic       w_read_op;

   assign w_accept  = req_valid && r_req_ready;
   assign w_read_op = r_op[3] && (r_op != OP_RDR);

   // Cycle type is chosen on entry to A1 tick 0 from the registered state only.
   always_comb begin
      w_tick_nxt = r_tick + 2'd1;
      w_slot_nxt = r_slot;
      w_cyc_nxt  = r_cyc;
      if (r_tick == 2'd3) begin
         w_slot_nxt = r_slot + 3'd1;
         if (r_slot == S_E3) begin
            if (r_cyc == CYC_SRC)
               w_cyc_nxt = CYC_IO;
            else if (r_pending)
               w_cyc_nxt = CYC_SRC;
            else
               w_cyc_nxt = CYC_NOP;
         end
      end
   end

   always_comb begin
      w_oe_nxt   = 1'b0;
      w_dout_nxt = 4'd0;
      case (w_slot_nxt)
         S_A1, S_A2: w_oe_nxt = 1'b1;
         S_A3: begin
            w_oe_nxt = 1'b1;
            if (w_cyc_nxt != CYC_NOP) w_dout_nxt = {r_chip, 2'b00};
         end
         S_M1: begin
            w_oe_nxt = 1'b1;
            if (w_cyc_nxt == CYC_SRC)     w_dout_nxt = OP_SRC;
            else if (w_cyc_nxt == CYC_IO) w_dout_nxt = OP_IOR;
         end
         S_M2: begin
            w_oe_nxt = 1'b1;
            if (w_cyc_nxt == CYC_SRC)     w_dout_nxt = SRC_OPA;
            else if (w_cyc_nxt == CYC_IO) w_dout_nxt = r_op;
         end
         S_E2: begin
            if (w_cyc_nxt == CYC_SRC) begin
               w_oe_nxt   = 1'b1;
               w_dout_nxt = r_addr[3:0];
            end else if (w_cyc_nxt == CYC_IO && !r_op[3]) begin
               w_oe_nxt   = 1'b1;
               w_dout_nxt = r_wdata;
            end
         end
         S_E3: begin
            if (w_cyc_nxt == CYC_SRC) begin
               w_oe_nxt   = 1'b1;
               w_dout_nxt = r_addr[7:4];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick        <= 2'd0;
         r_slot        <= S_E3;
         r_cyc         <= CYC_NOP;
         r_pending     <= 1'b0;
         r_req_ready   <= 1'b1;
         r_op          <= 4'd0;
         r_chip        <= 2'd0;
         r_addr        <= 8'd0;
         r_wdata       <= 4'd0;
         r_capt        <= 4'd0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= 4'd0;
         r_cp1         <= 1'b0;
         r_cp2         <= 1'b0;
         r_sync        <= 1'b0;
         r_cm          <= 1'b0;
         r_oe          <= 1'b0;
         r_dout        <= 4'd0;
         r_rst_d       <= 1'b0;
         r_bus_reset_n <= 1'b0;
      end else begin
         r_rst_d       <= 1'b1;
         r_bus_reset_n <= r_rst_d;
         r_tick        <= w_tick_nxt;
         r_slot        <= w_slot_nxt;
         r_cyc         <= w_cyc_nxt;
         // Outputs are registered from next-state so they line up with tick/slot.
         r_cp1         <= (w_tick_nxt == 2'd1);
         r_cp2         <= (w_tick_nxt == 2'd3);
         r_sync        <= (w_slot_nxt == S_A1) && !w_tick_nxt[1];
         r_cm          <= (w_cyc_nxt != CYC_NOP) && (w_slot_nxt >= S_M1);
         r_oe          <= w_oe_nxt;
         r_dout        <= w_dout_nxt;
         r_rsp_valid   <= 1'b0;

         if (w_accept) begin
            r_pending   <= 1'b1;
            r_req_ready <= 1'b0;
            r_op        <= req_op;
            r_chip      <= req_chip;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
         end

         if (r_rsp_valid) r_req_ready <= 1'b1;

         if (r_cyc == CYC_IO && r_slot == S_E2 && r_tick == 2'd2 && w_read_op)
            r_capt <= data;

         // Pending clears with the response so the following cycle is a NOP.
         if (w_cyc_nxt == CYC_IO && w_slot_nxt == S_E3 && w_tick_nxt == 2'd3) begin
            r_rsp_valid <= 1'b1;
            r_pending   <= 1'b0;
            r_rsp_rdata <= w_read_op ? r_capt : 4'd0;
         end
      end
   end

   assign data        = r_oe ? r_dout : 4'bz;
   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign cp1         = r_cp1;
   assign cp2         = r_cp2;
   assign sync        = r_sync;
   assign cm          = r_cm;
   assign bus_reset_n = r_bus_reset_n;

endmodule
